serial_compare_ctrl: RTL and testbench
======================================

# serial_compare_ctrl

Sequencer that compares two WIDTH-bit unsigned operands by driving a single external `onebit_comparator` one bit per cycle, MSB first, with early termination. It latches operands on a start pulse and walks the bit index downward. The first non-equal bit decides the result, which is reported with a one-cycle `done` pulse. It lets the one-bit comparator cell serve as a multi-bit magnitude comparator without replicating it.

## Interface
- `WIDTH`, 8, operand width in bits; legal range 2..32.

- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  request; sampled only in IDLE
- `a`  in  WIDTH  operand A; captured on an accepted start
- `b`  in  WIDTH  operand B; captured on an accepted start
- `bit_a`  out  1  bit of the latched A at the current index, to the comparator's `a`
- `bit_b`  out  1  bit of the latched B at the current index, to the comparator's `b`
- `bit_eq`, `bit_gre`, `bit_less`  in  1 each  combinational comparator response, same cycle
- `busy`  out  1  high while in SCAN
- `done`  out  1  one-cycle completion pulse
- `eq`, `gre`, `less`  out  1 each  registered result, one-hot after a valid compare
- `err`  out  1  registered flag; the comparator response was not one-hot

## Operation
- The FSM has three states: IDLE, SCAN and DONE. Reset state is IDLE.
- IDLE to SCAN happens on `start`=1:
  - `a` and `b` are latched into internal regs.
  - The index register loads WIDTH-1.
  - `eq`, `gre`, `less` and `err` clear to 0.
- In SCAN, `bit_a` = a_reg[idx] and `bit_b` = b_reg[idx]. The response is evaluated every cycle in this priority order:
  - Response not exactly one-hot (none set or more than one set): `err`=1, results stay 000, go to DONE.
  - `bit_gre`: `gre`=1, go to DONE.
  - `bit_less`: `less`=1, go to DONE.
  - `bit_eq` and idx==0: `eq`=1, go to DONE.
  - `bit_eq` and idx>0: idx decrements, stay in SCAN.
- DONE always returns to IDLE on the next edge.
- `start` is ignored in SCAN and DONE. There is no queueing.
- Results and `err` hold their values until the next accepted start.
- In IDLE and DONE, `bit_a` and `bit_b` drive 0.
- Changes on `a` and `b` after capture have no effect.
- Index width is clog2(WIDTH). The index never wraps below 0.

## Timing
- Reset values, applied asynchronously and independent of `clk`:
  - state = IDLE, idx = 0.
  - `busy`, `done`, `eq`, `gre`, `less`, `err`, `bit_a`, `bit_b` = 0.
- Edge E0 accepts `start`. `busy`=1 in the cycle after E0.
- Edge Ej (j ≥ 1) evaluates bit WIDTH-j.
- Let k be the highest differing bit. The compare terminates at edge En:
  - n = WIDTH-k when the operands differ.
  - n = WIDTH when the operands are equal.
- After En: `done`=1 for exactly one cycle, `busy`=0, and the results are valid. They stay valid afterwards.
- `start` can next be accepted at edge En+2, the first edge in IDLE.
- Back-to-back throughput is n+2 cycles per compare.
- Reset asserted mid-SCAN aborts the compare immediately. After release, the block is in IDLE and the first `start` behaves as fresh.
- `done` is never asserted together with `busy`.

## Test plan
All cases use WIDTH=8 and a behavioural one-bit comparator in the bench unless stated.

- **MSB differs.** `a`=0xA5, `b`=0x5A, `start` at E0 -> `gre`=1, `eq`=`less`=0, `done` high in the cycle after E1, `busy` high for 1 cycle.
- **LSB decides.** `a`=0x12, `b`=0x13 -> `less`=1 after E8. `bit_a`/`bit_b` sequence matches MSB to LSB. `busy` high 8 cycles.
- **Equal operands.** `a`=`b`=0x3C -> `eq`=1 after E8, `done` one cycle.
- **Start during busy.** `start` pulsed at E2 while scanning 0x00 vs 0x01 -> it is ignored, exactly one `done`, and the operands are not re-latched. `a`/`b` are changed mid-scan with no effect on the result.
- **Reset mid-scan.** `rst_n` is dropped at E3 between edges -> all outputs are 0 immediately. After release, `a`=0x80, `b`=0x7F gives `gre` after E1.
- **Bad response.** The bench forces `bit_eq`=`bit_gre`=1 at the first evaluated bit -> `err`=1, `eq`=`gre`=`less`=0, `done` pulses. The next valid compare clears `err`.

Source files
------------

// File: rtl/serial_compare_ctrl.sv
// serial_compare_ctrl
//
// Sequencer that uses one external single-bit comparator cell as a WIDTH-bit
// unsigned magnitude comparator. A start pulse in IDLE latches both operands.
// The sequencer then presents one bit pair per cycle, MSB first. The first
// bit pair that is not equal decides the result. Equal operands finish after
// the LSB. Completion is reported with a single-cycle done pulse.
//
// Ports
//   clk, rst_n              rising-edge clock, asynchronous active-low reset
//   start                   compare request, only honoured in IDLE
//   a, b                    operands, captured when start is accepted
//   bit_a, bit_b            current bit pair to the comparator (0 outside SCAN)
//   bit_eq/bit_gre/bit_less comparator response for the presented bit pair
//   busy                    high while bits are being scanned
//   done                    one-cycle completion pulse
//   eq, gre, less           result flags, held until the next accepted start
//   err                     comparator response was not one-hot
module serial_compare_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             bit_a,
  output logic             bit_b,
  input  logic             bit_eq,
  input  logic             bit_gre,
  input  logic             bit_less,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             gre,
  output logic             less,
  output logic             err
);

  localparam int IDX_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_reg, state_next;
  logic [WIDTH-1:0]   a_reg, a_next;
  logic [WIDTH-1:0]   b_reg, b_next;
  logic [IDX_W-1:0]   idx_reg, idx_next;
  logic               eq_reg, eq_next;
  logic               gre_reg, gre_next;
  logic               less_reg, less_next;
  logic               err_reg, err_next;
  logic               resp_onehot;

  // Exactly one of three bits set: odd parity excludes zero and two set bits,
  // and the AND term excludes all three set.
  assign resp_onehot = (bit_eq ^ bit_gre ^ bit_less) & ~(bit_eq & bit_gre & bit_less);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      idx_reg   <= '0;
      eq_reg    <= 1'b0;
      gre_reg   <= 1'b0;
      less_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      idx_reg   <= idx_next;
      eq_reg    <= eq_next;
      gre_reg   <= gre_next;
      less_reg  <= less_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    idx_next   = idx_reg;
    eq_next    = eq_reg;
    gre_next   = gre_reg;
    less_next  = less_reg;
    err_next   = err_reg;

    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = SCAN;
          a_next     = a;
          b_next     = b;
          idx_next   = IDX_W'(WIDTH - 1);
          eq_next    = 1'b0;
          gre_next   = 1'b0;
          less_next  = 1'b0;
          err_next   = 1'b0;
        end
      end
      SCAN: begin
        if (!resp_onehot) begin
          err_next   = 1'b1;
          state_next = DONE;
        end else if (bit_gre) begin
          gre_next   = 1'b1;
          state_next = DONE;
        end else if (bit_less) begin
          less_next  = 1'b1;
          state_next = DONE;
        end else if (idx_reg == '0) begin
          // Every bit matched down to the LSB.
          eq_next    = 1'b1;
          state_next = DONE;
        end else begin
          idx_next   = idx_reg - 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // All status outputs decode from registered state, so the asynchronous reset
  // drives them to zero without waiting for a clock edge.
  assign busy  = (state_reg == SCAN);
  assign done  = (state_reg == DONE);
  assign bit_a = busy & a_reg[idx_reg];
  assign bit_b = busy & b_reg[idx_reg];
  assign eq    = eq_reg;
  assign gre   = gre_reg;
  assign less  = less_reg;
  assign err   = err_reg;

endmodule

// File: tb/tb_serial_compare_ctrl.sv
// Directed testbench for serial_compare_ctrl (WIDTH=8) with a behavioural
// one-bit comparator. The comparator can be overridden to give a bad response.
module tb_serial_compare_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       bit_a;
  logic       bit_b;
  logic       bit_eq;
  logic       bit_gre;
  logic       bit_less;
  logic       busy;
  logic       done;
  logic       eq;
  logic       gre;
  logic       less;
  logic       err;
  logic       bad_resp;

  int checks;
  int errors;

  serial_compare_ctrl #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .bit_a    (bit_a),
    .bit_b    (bit_b),
    .bit_eq   (bit_eq),
    .bit_gre  (bit_gre),
    .bit_less (bit_less),
    .busy     (busy),
    .done     (done),
    .eq       (eq),
    .gre      (gre),
    .less     (less),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural comparator cell; bad_resp forces eq and gre together.
  always_comb begin
    bit_eq   = (bit_a == bit_b);
    bit_gre  = bit_a & ~bit_b;
    bit_less = ~bit_a & bit_b;
    if (bad_resp) begin
      bit_eq   = 1'b1;
      bit_gre  = 1'b1;
      bit_less = 1'b0;
    end
  end

  task automatic check(input string tag, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
    end else begin
      $display("ok   %s: %0d", tag, actual);
    end
  endtask

  // Runs one compare starting from IDLE. exp_n is the terminating edge index.
  // With mid_start set, start is pulsed at E2 with new operands, and the
  // operands stay changed for the rest of the scan.
  task automatic run_cmp(input string tag, input logic [7:0] av, input logic [7:0] bv,
                         input int exp_n, input logic exp_eq, input logic exp_gre,
                         input logic exp_less, input logic exp_err, input bit mid_start);
    int busy_cnt;
    int done_edge;
    int bit_bad;
    int both_cnt;
    int extra_done;
    a     = av;
    b     = bv;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    busy_cnt  = 0;
    done_edge = -1;
    bit_bad   = 0;
    both_cnt  = 0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      if (busy && done) both_cnt++;
      if (busy) begin
        busy_cnt++;
        if (cyc > 8) bit_bad++;
        else if (bit_a !== av[8-cyc] || bit_b !== bv[8-cyc]) bit_bad++;
      end
      if (done) begin
        done_edge = cyc - 1;
        break;
      end
      if (mid_start && cyc == 2) begin
        start = 1'b1;
        a     = 8'hFF;
        b     = 8'h00;
      end
      @(posedge clk);
      #1 start = 1'b0;
    end
    check({tag, " done_edge"}, done_edge, exp_n);
    check({tag, " busy_cycles"}, busy_cnt, exp_n);
    check({tag, " bit_seq_errs"}, bit_bad, 0);
    check({tag, " busy_with_done"}, both_cnt, 0);
    check({tag, " result"}, {28'd0, eq, gre, less, err},
          {28'd0, exp_eq, exp_gre, exp_less, exp_err});
    // Done must be a single pulse; nothing restarts, results hold.
    extra_done = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      if (done || busy) extra_done++;
    end
    check({tag, " extra_done_busy"}, extra_done, 0);
    check({tag, " result_hold"}, {28'd0, eq, gre, less, err},
          {28'd0, exp_eq, exp_gre, exp_less, exp_err});
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    a        = 8'h00;
    b        = 8'h00;
    bad_resp = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset outputs", {24'd0, busy, done, eq, gre, less, err, bit_a, bit_b}, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_cmp("msb_differs", 8'hA5, 8'h5A, 1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    run_cmp("lsb_decides", 8'h12, 8'h13, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    run_cmp("equal",       8'h3C, 8'h3C, 8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    run_cmp("bit4_gre",    8'hF0, 8'hE0, 4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    run_cmp("start_busy",  8'h00, 8'h01, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

    // Reset in the middle of a scan, between E2 and E3.
    a     = 8'h00;
    b     = 8'h01;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("pre_reset busy", {31'd0, busy}, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async reset outputs", {24'd0, busy, done, eq, gre, less, err, bit_a, bit_b}, 0);
    @(posedge clk);
    #1;
    check("held reset outputs", {24'd0, busy, done, eq, gre, less, err, bit_a, bit_b}, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_cmp("after_reset", 8'h80, 8'h7F, 1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    bad_resp = 1'b1;
    run_cmp("bad_resp", 8'h55, 8'h55, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    bad_resp = 1'b0;
    run_cmp("err_clears", 8'h01, 8'h00, 8, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
